// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: forward-resolved operand capture, load-use
// interlock (one bubble), memory-stall freeze and branch flush.
module id_ex_latch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_reg1_data,
  input  logic [DATA_W-1:0] id_reg2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [ADDR_W-1:0] id_reg1_addr,
  input  logic [ADDR_W-1:0] id_reg2_addr,
  input  logic [ADDR_W-1:0] id_wb_addr,
  input  logic              id_uses_reg1,
  input  logic              id_uses_reg2,
  input  logic [3:0]        id_alu_op,
  input  logic [2:0]        id_op1_mux_op,
  input  logic [2:0]        id_op2_mux_op,
  input  logic [2:0]        id_reg_op,
  input  logic [2:0]        id_wb_data_op,
  input  logic [1:0]        id_mem_op,
  input  logic              reg1_forward_enable,
  input  logic              reg2_forward_enable,
  input  logic [DATA_W-1:0] reg1_forward_data,
  input  logic [DATA_W-1:0] reg2_forward_data,
  input  logic              mem_stall,
  input  logic              flush,
  output logic [DATA_W-1:0] ie_pc,
  output logic [DATA_W-1:0] ie_reg1_data,
  output logic [DATA_W-1:0] ie_reg2_data,
  output logic [DATA_W-1:0] ie_imm,
  output logic [ADDR_W-1:0] ie_reg1_addr,
  output logic [ADDR_W-1:0] ie_reg2_addr,
  output logic [ADDR_W-1:0] ie_wb_addr,
  output logic [3:0]        ie_alu_op,
  output logic [2:0]        ie_op1_mux_op,
  output logic [2:0]        ie_op2_mux_op,
  output logic [2:0]        ie_reg_op,
  output logic [2:0]        ie_wb_data_op,
  output logic [1:0]        ie_mem_op,
  output logic              ie_valid,
  output logic              id_stall,
  output logic [15:0]       bubble_count,
  output logic              dbg_state
);

  typedef enum logic {RUN = 1'b0, LU_WAIT = 1'b1} state_t;

  localparam logic [2:0] REG_OP_REG = 3'd1;
  localparam logic [2:0] WB_OP_MEM  = 3'd2;

  state_t              r_state;
  logic [DATA_W-1:0]   r_pc, r_reg1_data, r_reg2_data, r_imm;
  logic [ADDR_W-1:0]   r_reg1_addr, r_reg2_addr, r_wb_addr;
  logic [3:0]          r_alu_op;
  logic [2:0]          r_op1_mux_op, r_op2_mux_op, r_reg_op, r_wb_data_op;
  logic [1:0]          r_mem_op;
  logic                r_valid;
  logic [15:0]         r_bubble_count;

  logic [DATA_W-1:0]   w_reg1_sel, w_reg2_sel;
  logic                w_ex_is_load, w_hz, w_lu_hit, w_bubble;
  state_t              w_state_nxt;

  assign w_reg1_sel = reg1_forward_enable ? reg1_forward_data : id_reg1_data;
  assign w_reg2_sel = reg2_forward_enable ? reg2_forward_data : id_reg2_data;

  // Hazard uses only registered EX fields and ID addresses: no path from forward_* to id_stall.
  assign w_ex_is_load = r_valid && (r_wb_data_op == WB_OP_MEM) && (r_reg_op == REG_OP_REG);
  assign w_hz = w_ex_is_load &&
                ((id_uses_reg1 && (id_reg1_addr == r_wb_addr)) ||
                 (id_uses_reg2 && (id_reg2_addr == r_wb_addr)));

  assign w_lu_hit    = (r_state == RUN) && w_hz && !flush;
  assign w_bubble    = flush || ((r_state == RUN) && w_hz);
  assign w_state_nxt = w_lu_hit ? LU_WAIT : RUN;

  assign id_stall = mem_stall || w_lu_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_pc           <= '0;
      r_reg1_data    <= '0;
      r_reg2_data    <= '0;
      r_imm          <= '0;
      r_reg1_addr    <= '0;
      r_reg2_addr    <= '0;
      r_wb_addr      <= '0;
      r_alu_op       <= '0;
      r_op1_mux_op   <= '0;
      r_op2_mux_op   <= '0;
      r_reg_op       <= '0;
      r_wb_data_op   <= '0;
      r_mem_op       <= '0;
      r_valid        <= 1'b0;
      r_bubble_count <= '0;
    end else if (!mem_stall) begin
      r_state <= w_state_nxt;
      if (w_bubble) begin
        r_pc           <= '0;
        r_reg1_data    <= '0;
        r_reg2_data    <= '0;
        r_imm          <= '0;
        r_reg1_addr    <= '0;
        r_reg2_addr    <= '0;
        r_wb_addr      <= '0;
        r_alu_op       <= '0;
        r_op1_mux_op   <= '0;
        r_op2_mux_op   <= '0;
        r_reg_op       <= '0;
        r_wb_data_op   <= '0;
        r_mem_op       <= '0;
        r_valid        <= 1'b0;
        r_bubble_count <= r_bubble_count + 16'd1;
      end else begin
        r_pc           <= id_pc;
        r_reg1_data    <= w_reg1_sel;
        r_reg2_data    <= w_reg2_sel;
        r_imm          <= id_imm;
        r_reg1_addr    <= id_reg1_addr;
        r_reg2_addr    <= id_reg2_addr;
        r_wb_addr      <= id_wb_addr;
        r_alu_op       <= id_alu_op;
        r_op1_mux_op   <= id_op1_mux_op;
        r_op2_mux_op   <= id_op2_mux_op;
        r_reg_op       <= id_reg_op;
        r_wb_data_op   <= id_wb_data_op;
        r_mem_op       <= id_mem_op;
        r_valid        <= 1'b1;
      end
    end
  end

  assign ie_pc         = r_pc;
  assign ie_reg1_data  = r_reg1_data;
  assign ie_reg2_data  = r_reg2_data;
  assign ie_imm        = r_imm;
  assign ie_reg1_addr  = r_reg1_addr;
  assign ie_reg2_addr  = r_reg2_addr;
  assign ie_wb_addr    = r_wb_addr;
  assign ie_alu_op     = r_alu_op;
  assign ie_op1_mux_op = r_op1_mux_op;
  assign ie_op2_mux_op = r_op2_mux_op;
  assign ie_reg_op     = r_reg_op;
  assign ie_wb_data_op = r_wb_data_op;
  assign ie_mem_op     = r_mem_op;
  assign ie_valid      = r_valid;
  assign bubble_count  = r_bubble_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: driver pushes the expected EX-stage view per edge,
// a monitor pops and compares one time unit after each rising edge.
module tb_id_ex_latch;

  logic        clk, rst;
  logic [15:0] id_pc, id_reg1_data, id_reg2_data, id_imm;
  logic [3:0]  id_reg1_addr, id_reg2_addr, id_wb_addr;
  logic        id_uses_reg1, id_uses_reg2;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_op1_mux_op, id_op2_mux_op, id_reg_op, id_wb_data_op;
  logic [1:0]  id_mem_op;
  logic        reg1_forward_enable, reg2_forward_enable;
  logic [15:0] reg1_forward_data, reg2_forward_data;
  logic        mem_stall, flush;
  logic [15:0] ie_pc, ie_reg1_data, ie_reg2_data, ie_imm;
  logic [3:0]  ie_reg1_addr, ie_reg2_addr, ie_wb_addr;
  logic [3:0]  ie_alu_op;
  logic [2:0]  ie_op1_mux_op, ie_op2_mux_op, ie_reg_op, ie_wb_data_op;
  logic [1:0]  ie_mem_op;
  logic        ie_valid, id_stall, dbg_state;
  logic [15:0] bubble_count;

  id_ex_latch dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_reg1_data(id_reg1_data), .id_reg2_data(id_reg2_data), .id_imm(id_imm),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr), .id_wb_addr(id_wb_addr),
    .id_uses_reg1(id_uses_reg1), .id_uses_reg2(id_uses_reg2),
    .id_alu_op(id_alu_op), .id_op1_mux_op(id_op1_mux_op), .id_op2_mux_op(id_op2_mux_op),
    .id_reg_op(id_reg_op), .id_wb_data_op(id_wb_data_op), .id_mem_op(id_mem_op),
    .reg1_forward_enable(reg1_forward_enable), .reg2_forward_enable(reg2_forward_enable),
    .reg1_forward_data(reg1_forward_data), .reg2_forward_data(reg2_forward_data),
    .mem_stall(mem_stall), .flush(flush),
    .ie_pc(ie_pc), .ie_reg1_data(ie_reg1_data), .ie_reg2_data(ie_reg2_data), .ie_imm(ie_imm),
    .ie_reg1_addr(ie_reg1_addr), .ie_reg2_addr(ie_reg2_addr), .ie_wb_addr(ie_wb_addr),
    .ie_alu_op(ie_alu_op), .ie_op1_mux_op(ie_op1_mux_op), .ie_op2_mux_op(ie_op2_mux_op),
    .ie_reg_op(ie_reg_op), .ie_wb_data_op(ie_wb_data_op), .ie_mem_op(ie_mem_op),
    .ie_valid(ie_valid), .id_stall(id_stall), .bubble_count(bubble_count), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        v;
    logic        st;
    logic [15:0] pc, r1, r2, imm;
    logic [3:0]  a1, a2, wa, alu;
    logic [2:0]  m1, m2, rop, wbop;
    logic [1:0]  mop;
    logic [15:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string nm_q[$];
  int    errors = 0;
  int    checks = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.v = ie_valid; o.st = dbg_state;
    o.pc = ie_pc; o.r1 = ie_reg1_data; o.r2 = ie_reg2_data; o.imm = ie_imm;
    o.a1 = ie_reg1_addr; o.a2 = ie_reg2_addr; o.wa = ie_wb_addr; o.alu = ie_alu_op;
    o.m1 = ie_op1_mux_op; o.m2 = ie_op2_mux_op; o.rop = ie_reg_op; o.wbop = ie_wb_data_op;
    o.mop = ie_mem_op; o.cnt = bubble_count;
    return o;
  endfunction

  // Expected captured instruction; the side fields follow the same pc-derived encoding the driver uses.
  function automatic obs_t ex(input logic [15:0] pc, input logic [3:0] a1, a2, wa,
                              input logic ld, input logic [15:0] r1, r2, cnt);
    obs_t o;
    o.v = 1'b1; o.st = 1'b0;
    o.pc = pc; o.r1 = r1; o.r2 = r2; o.imm = ~pc;
    o.a1 = a1; o.a2 = a2; o.wa = wa; o.alu = pc[3:0];
    o.m1 = pc[6:4]; o.m2 = pc[9:7]; o.rop = 3'd1; o.wbop = ld ? 3'd2 : 3'd1;
    o.mop = ld ? 2'd1 : 2'd0; o.cnt = cnt;
    return o;
  endfunction

  function automatic obs_t bub(input logic [15:0] cnt, input logic st);
    obs_t o;
    o = '0;
    o.cnt = cnt; o.st = st;
    return o;
  endfunction

  task automatic chk_obs(input string nm, input obs_t act, input obs_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, expv);
    end
  endtask

  // monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk_obs(nm_q.pop_front(), sample(), exp_q.pop_front());
  end

  // driver tasks
  task automatic drive(input logic [15:0] pc, input logic [3:0] a1, input logic u1,
                       input logic [3:0] a2, input logic u2, input logic [3:0] wa, input logic ld,
                       input logic [15:0] d1, d2, input logic fe1, input logic [15:0] fd1,
                       input logic fe2, input logic [15:0] fd2);
    id_pc = pc; id_imm = ~pc; id_alu_op = pc[3:0]; id_op1_mux_op = pc[6:4]; id_op2_mux_op = pc[9:7];
    id_reg1_addr = a1; id_uses_reg1 = u1; id_reg2_addr = a2; id_uses_reg2 = u2; id_wb_addr = wa;
    id_reg_op = 3'd1; id_wb_data_op = ld ? 3'd2 : 3'd1; id_mem_op = ld ? 2'd1 : 2'd0;
    id_reg1_data = d1; id_reg2_data = d2;
    reg1_forward_enable = fe1; reg1_forward_data = fd1;
    reg2_forward_enable = fe2; reg2_forward_data = fd2;
  endtask

  task automatic drv_ld(input logic [15:0] pc, input logic [3:0] wa);
    drive(pc, 4'd2, 1'b1, 4'd0, 1'b0, wa, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // Checks id_stall just before the edge, then queues the post-edge expectation.
  task automatic step(input obs_t e, input logic exp_stall, input string nm);
    #1;
    chk_bit({nm, "_stall"}, id_stall, exp_stall);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  task automatic mid_reset(input string nm);
    #3;
    rst = 1'b1;
    #1;
    chk_obs(nm, sample(), bub(16'h0, 1'b0));
    chk_bit({nm, "_stall"}, id_stall, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0; flush = 1'b0;
    drive(16'h0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    #3;
    chk_obs("reset", sample(), bub(16'h0, 1'b0));
    chk_bit("reset_stall", id_stall, 1'b0);
    mem_stall = 1'b1;
    #1;
    chk_bit("reset_stall_mem", id_stall, 1'b1);
    mem_stall = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;

    // forwarding select per operand
    drive(16'h0010, 4'd1, 1'b1, 4'd2, 1'b1, 4'd5, 1'b0, 16'h1111, 16'h2222, 1'b1, 16'hBEEF, 1'b0, 16'h0);
    step(ex(16'h0010, 4'd1, 4'd2, 4'd5, 1'b0, 16'hBEEF, 16'h2222, 16'd0), 1'b0, "fwd1_en");
    drive(16'h0011, 4'd5, 1'b1, 4'd6, 1'b1, 4'd7, 1'b0, 16'h1111, 16'h3333, 1'b0, 16'hBEEF, 1'b1, 16'hCAFE);
    step(ex(16'h0011, 4'd5, 4'd6, 4'd7, 1'b0, 16'h1111, 16'hCAFE, 16'd0), 1'b0, "fwd2_en");

    // load-use on reg1: one bubble, then the held instruction enters EX
    drv_ld(16'h0020, 4'd3);
    step(ex(16'h0020, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0100, 16'h0000, 16'd0), 1'b0, "load1");
    drive(16'h0021, 4'd3, 1'b1, 4'd4, 1'b1, 4'd8, 1'b0, 16'h0000, 16'h0444, 1'b0, 16'h0, 1'b0, 16'h0);
    step(bub(16'd1, 1'b1), 1'b1, "lu_bubble");
    drive(16'h0021, 4'd3, 1'b1, 4'd4, 1'b1, 4'd8, 1'b0, 16'h0000, 16'h0444, 1'b1, 16'h5A5A, 1'b0, 16'h0);
    step(ex(16'h0021, 4'd3, 4'd4, 4'd8, 1'b0, 16'h5A5A, 16'h0444, 16'd1), 1'b0, "lu_resume");

    // no false hazard: unused source, different register
    drv_ld(16'h0030, 4'd3);
    step(ex(16'h0030, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0100, 16'h0000, 16'd1), 1'b0, "load2");
    drive(16'h0031, 4'd3, 1'b0, 4'd4, 1'b1, 4'd8, 1'b0, 16'h0777, 16'h0444, 1'b0, 16'h0, 1'b0, 16'h0);
    step(ex(16'h0031, 4'd3, 4'd4, 4'd8, 1'b0, 16'h0777, 16'h0444, 16'd1), 1'b0, "no_hz_unused");
    drv_ld(16'h0032, 4'd3);
    step(ex(16'h0032, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0100, 16'h0000, 16'd1), 1'b0, "load3");
    drive(16'h0033, 4'd4, 1'b1, 4'd4, 1'b1, 4'd9, 1'b0, 16'h0888, 16'h0999, 1'b0, 16'h0, 1'b0, 16'h0);
    step(ex(16'h0033, 4'd4, 4'd4, 4'd9, 1'b0, 16'h0888, 16'h0999, 16'd1), 1'b0, "no_hz_r4");

    // load-use through reg2
    drv_ld(16'h0034, 4'd3);
    step(ex(16'h0034, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0100, 16'h0000, 16'd1), 1'b0, "load4");
    drive(16'h0035, 4'd1, 1'b1, 4'd3, 1'b1, 4'd9, 1'b0, 16'h0abc, 16'h0def, 1'b0, 16'h0, 1'b0, 16'h0);
    step(bub(16'd2, 1'b1), 1'b1, "lu_reg2");
    step(ex(16'h0035, 4'd1, 4'd3, 4'd9, 1'b0, 16'h0abc, 16'h0def, 16'd2), 1'b0, "lu_reg2_resume");

    // flush wins over hazard: single bubble, state RUN, no stall
    drv_ld(16'h0040, 4'd3);
    step(ex(16'h0040, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0100, 16'h0000, 16'd2), 1'b0, "load5");
    drive(16'h0041, 4'd3, 1'b1, 4'd4, 1'b1, 4'd8, 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h0, 1'b0, 16'h0);
    flush = 1'b1;
    step(bub(16'd3, 1'b0), 1'b0, "flush_hz");
    flush = 1'b0;
    drive(16'h0042, 4'd3, 1'b1, 4'd4, 1'b1, 4'd8, 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h0, 1'b0, 16'h0);
    step(ex(16'h0042, 4'd3, 4'd4, 4'd8, 1'b0, 16'h1234, 16'h5678, 16'd3), 1'b0, "after_flush");

    // freeze with a pending hazard, then freeze while in LU_WAIT
    drv_ld(16'h0050, 4'd3);
    step(ex(16'h0050, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0100, 16'h0000, 16'd3), 1'b0, "load6");
    mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(16'h0051 + 16'(k), 4'd3, 1'b1, 4'd4, 1'b1, 4'd8, 1'b0, 16'h1000 + 16'(k), 16'h2000, 1'b0, 16'h0, 1'b0, 16'h0);
      step(ex(16'h0050, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0100, 16'h0000, 16'd3), 1'b1, "freeze");
    end
    mem_stall = 1'b0;
    drive(16'h0054, 4'd3, 1'b1, 4'd4, 1'b1, 4'd8, 1'b0, 16'h0000, 16'h2000, 1'b1, 16'h7777, 1'b0, 16'h0);
    step(bub(16'd4, 1'b1), 1'b1, "freeze_release_hz");
    mem_stall = 1'b1;
    step(bub(16'd4, 1'b1), 1'b1, "freeze_lu_wait");
    mem_stall = 1'b0;
    step(ex(16'h0054, 4'd3, 4'd4, 4'd8, 1'b0, 16'h7777, 16'h2000, 16'd4), 1'b0, "lu_after_freeze");

    // async reset while EX holds a valid instruction
    mid_reset("rst_valid");

    // async reset while in LU_WAIT
    drv_ld(16'h0060, 4'd3);
    step(ex(16'h0060, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0100, 16'h0000, 16'd0), 1'b0, "load7");
    drive(16'h0061, 4'd3, 1'b1, 4'd4, 1'b1, 4'd8, 1'b0, 16'h4321, 16'h8765, 1'b0, 16'h0, 1'b0, 16'h0);
    step(bub(16'd1, 1'b1), 1'b1, "lu_before_rst");
    mid_reset("rst_lu_wait");
    step(ex(16'h0061, 4'd3, 4'd4, 4'd8, 1'b0, 16'h4321, 16'h8765, 16'd0), 1'b0, "post_rst_run");

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
